// File: rtl/boot_loader_pkg.sv
// Boot loader shared definitions: sync byte, default load address and
// FSM state encoding used by boot_loader and boot_checksum.
package boot_loader_pkg;

    localparam logic [7:0] BOOT_SYNC_BYTE = 8'hA5;
    localparam logic [7:0] BOOT_LOAD_BASE = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CHK  = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } boot_state_t;

endpackage

// File: rtl/boot_checksum.sv
// Clearable 8-bit wrapping accumulator; zero flags that the running sum
// plus the byte currently presented on byte_in is 0 mod 256.
module boot_checksum
    import boot_loader_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       add_en,
    input  logic [7:0] byte_in,
    output logic [7:0] sum_out,
    output logic       zero
);

    logic [7:0] sum_q;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            sum_q <= 8'd0;
        end else if (add_en) begin
            sum_q <= sum_q + byte_in;
        end
    end

    assign sum_out = sum_q;
    assign zero    = (sum_q + byte_in) == 8'd0;

endmodule

// File: rtl/boot_loader.sv
// Framed byte-stream program loader; holds the CPU in reset until loaded.
// Define BOOT_LOADER_CHECKSUM_EN to expect and verify a trailing CHK byte.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] LOAD_BASE  = ADDR_WIDTH'(BOOT_LOAD_BASE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [7:0]            mem_data,
    output logic                  mem_we,
    output logic                  mem_cs,
    output logic                  cpu_reset,
    output logic                  load_done,
    output logic                  load_error
);

    boot_state_t           state, state_nx;
    logic [7:0]            len_q;
    logic [7:0]            cnt_q;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            data_q;
    logic                  we_q;
    logic                  accept;
    logic                  ld_len;
    logic                  wr;
    logic                  last;
    logic                  chk_ok;

`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam boot_state_t LAST_NX = ST_CHK;
    logic [7:0] sum_unused;

    boot_checksum u_chk (
        .clk     (clk),
        .reset   (reset),
        .clr     (ld_len),
        .add_en  (wr),
        .byte_in (rx_data),
        .sum_out (sum_unused),
        .zero    (chk_ok)
    );
`else
    localparam boot_state_t LAST_NX = ST_DONE;
    assign chk_ok = 1'b0;
`endif

    assign accept = rx_valid && rx_ready;
    assign last   = (cnt_q + 8'd1) == len_q;

    always_comb begin
        state_nx = state;
        ld_len   = 1'b0;
        wr       = 1'b0;
        unique case (state)
            ST_IDLE, ST_ERR: begin
                if (accept && rx_data == BOOT_SYNC_BYTE) state_nx = ST_LEN;
            end
            ST_LEN: begin
                if (accept) begin
                    if (rx_data == 8'd0) begin
                        state_nx = ST_ERR;
                    end else begin
                        state_nx = ST_DATA;
                        ld_len   = 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    wr = 1'b1;
                    if (last) state_nx = LAST_NX;
                end
            end
            ST_CHK: begin
                if (accept) state_nx = chk_ok ? ST_DONE : ST_ERR;
            end
            ST_DONE: state_nx = ST_DONE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            len_q  <= 8'd0;
            cnt_q  <= 8'd0;
            wr_ptr <= LOAD_BASE;
            addr_q <= LOAD_BASE;
            data_q <= 8'd0;
            we_q   <= 1'b0;
        end else begin
            state <= state_nx;
            we_q  <= wr;
            if (ld_len) begin
                len_q  <= rx_data;
                cnt_q  <= 8'd0;
                wr_ptr <= LOAD_BASE;
            end
            if (wr) begin
                addr_q <= wr_ptr;
                data_q <= rx_data;
                wr_ptr <= wr_ptr + 1'b1;
                cnt_q  <= cnt_q + 8'd1;
            end
        end
    end

    // Release waits for the final write strobe so the CPU never races it.
    assign load_done   = (state == ST_DONE) && !we_q;
    assign cpu_reset   = !load_done;
    assign load_error  = (state == ST_ERR);
    assign rx_ready    = (state != ST_DONE);
    assign mem_address = addr_q;
    assign mem_data    = data_q;
    assign mem_we      = we_q;
    assign mem_cs      = we_q;

endmodule

// File: tb/tb_boot_loader.sv
// Randomized bench for boot_loader with a frame-level reference model.
module tb_boot_loader;
    import boot_loader_pkg::*;

`ifdef BOOT_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif
    localparam logic [7:0] LB = BOOT_LOAD_BASE;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] mem_address;
    logic [7:0] mem_data;
    logic       mem_we;
    logic       mem_cs;
    logic       cpu_reset;
    logic       load_done;
    logic       load_error;

    always #5 clk = ~clk;

    boot_loader dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_we      (mem_we),
        .mem_cs      (mem_cs),
        .cpu_reset   (cpu_reset),
        .load_done   (load_done),
        .load_error  (load_error)
    );

    // Reference model: tracks bytes seen since the latest SYNC
    bit         m_hunt = 1'b1;
    bit         m_fin  = 1'b0;
    bit         m_done = 1'b0;
    bit         m_err  = 1'b0;
    bit         m_pend = 1'b0;
    bit         m_we   = 1'b0;
    logic [7:0] m_addr = LB;
    logic [7:0] m_data = 8'd0;
    logic [7:0] m_buf[$];
    logic [7:0] model_ram[256];

    task automatic model_byte(input logic [7:0] b);
        int n;
        int idx;
        int s;
        if (m_hunt) begin
            if (b == BOOT_SYNC_BYTE) begin
                m_hunt = 1'b0;
                m_err  = 1'b0;
                m_buf.delete();
            end
            return;
        end
        m_buf.push_back(b);
        n   = int'(m_buf[0]);
        idx = m_buf.size() - 1;
        if (n == 0) begin
            m_err  = 1'b1;
            m_hunt = 1'b1;
            return;
        end
        if (idx >= 1 && idx <= n) begin
            m_we   = 1'b1;
            m_addr = 8'(int'(LB) + idx - 1);
            m_data = b;
            model_ram[m_addr] = b;
        end
        if (!CHK_EN && idx == n) begin
            m_fin  = 1'b1;
            m_pend = 1'b1;
        end
        if (CHK_EN && idx == n + 1) begin
            s = 0;
            for (int i = 1; i <= n + 1; i++) s += int'(m_buf[i]);
            if (s % 256 == 0) begin
                m_fin  = 1'b1;
                m_done = 1'b1;
            end else begin
                m_err  = 1'b1;
                m_hunt = 1'b1;
            end
        end
    endtask

    always @(posedge clk) begin
        if (reset) begin
            m_hunt = 1'b1;
            m_fin  = 1'b0;
            m_done = 1'b0;
            m_err  = 1'b0;
            m_pend = 1'b0;
            m_we   = 1'b0;
            m_addr = LB;
            m_data = 8'd0;
            m_buf.delete();
        end else begin
            m_we = 1'b0;
            if (m_pend) begin
                m_done = 1'b1;
                m_pend = 1'b0;
            end
            if (rx_valid && !m_fin) model_byte(rx_data);
        end
    end

    // Compare process
    int         n_cmp = 0;
    int         n_bad = 0;
    int         we_cnt = 0;
    int         probe = 0;
    int         wb = 0;
    bit         check_en = 1'b0;
    logic [7:0] dut_ram[256];
    int         bad_at;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (check_en) begin
            if (mem_we && mem_cs) begin
                dut_ram[mem_address] = mem_data;
                we_cnt++;
            end
            chk("rx_ready", 32'(rx_ready), 32'(!m_fin));
            chk("cpu_reset", 32'(cpu_reset), 32'(!m_done));
            chk("load_done", 32'(load_done), 32'(m_done));
            chk("load_error", 32'(load_error), 32'(m_err));
            chk("mem_we", 32'(mem_we), 32'(m_we));
            chk("mem_cs", 32'(mem_cs), 32'(m_we));
            chk("mem_address", 32'(mem_address), 32'(m_addr));
            chk("mem_data", 32'(mem_data), 32'(m_data));
            case (probe)
                10: begin
                    chk("rst_addr", 32'(mem_address), 32'h00);
                    chk("rst_data", 32'(mem_data), 32'h00);
                    chk("rst_ready", 32'(rx_ready), 32'h1);
                    chk("rst_cpu_reset", 32'(cpu_reset), 32'h1);
                end
                1: begin
                    chk("a_ram0", 32'(dut_ram[0]), 32'h11);
                    chk("a_ram1", 32'(dut_ram[1]), 32'h22);
                    chk("a_ram2", 32'(dut_ram[2]), 32'h33);
                    chk("a_we_count", 32'(we_cnt - wb), 32'd3);
                    chk("a_done", 32'(load_done), 32'h1);
                    chk("a_cpu_reset", 32'(cpu_reset), 32'h0);
                end
                2: begin
                    chk("bad_error", 32'(load_error), 32'h1);
                    chk("bad_cpu_reset", 32'(cpu_reset), 32'h1);
                    chk("bad_done", 32'(load_done), 32'h0);
                end
                3: begin
                    chk("rec_ram0", 32'(dut_ram[0]), 32'h7E);
                    chk("rec_done", 32'(load_done), 32'h1);
                    chk("rec_error", 32'(load_error), 32'h0);
                end
                4: begin
                    chk("garb_ram0", 32'(dut_ram[0]), 32'hC3);
                    chk("garb_we_count", 32'(we_cnt - wb), 32'd1);
                    chk("garb_done", 32'(load_done), 32'h1);
                end
                5: begin
                    chk("len0_error", 32'(load_error), 32'h1);
                    chk("len0_we_count", 32'(we_cnt - wb), 32'd0);
                    chk("len0_cpu_reset", 32'(cpu_reset), 32'h1);
                end
                6: begin
                    chk("mid_cpu_reset", 32'(cpu_reset), 32'h1);
                    chk("mid_done", 32'(load_done), 32'h0);
                    chk("mid_ready", 32'(rx_ready), 32'h1);
                    chk("mid_ram0", 32'(dut_ram[0]), 32'h01);
                    chk("mid_ram1", 32'(dut_ram[1]), 32'h02);
                end
                7: begin
                    chk("after_ram0", 32'(dut_ram[0]), 32'h55);
                    chk("after_ram1", 32'(dut_ram[1]), 32'h02);
                    chk("after_done", 32'(load_done), 32'h1);
                end
                8: begin
                    chk("tog_ram0", 32'(dut_ram[0]), 32'h10);
                    chk("tog_ram1", 32'(dut_ram[1]), 32'h20);
                    chk("tog_ram2", 32'(dut_ram[2]), 32'h30);
                    chk("tog_ram3", 32'(dut_ram[3]), 32'h40);
                    chk("tog_we_count", 32'(we_cnt - wb), 32'd4);
                    chk("tog_done_ready", 32'(rx_ready), 32'h0);
                end
                9: begin
                    bad_at = 0;
                    for (int i = 255; i >= 0; i--) begin
                        if (dut_ram[i] !== model_ram[i]) bad_at = i;
                    end
                    chk("ram_image", 32'(dut_ram[bad_at]), 32'(model_ram[bad_at]));
                end
                default: ;
            endcase
        end
    end

    // Stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        repeat (gap) tick();
    endtask

    // mode 0: back-to-back, 1: random gaps, 2: valid toggles 1,0,1,0
    task automatic send(input bq_t q, input int mode);
        int g;
        foreach (q[i]) begin
            g = (mode == 0) ? 0 : (mode == 2) ? 1 : int'($urandom_range(0, 2));
            put(q[i], g);
        end
    endtask

    function automatic bq_t frame(input bq_t pl, input logic [7:0] tweak);
        bq_t        f;
        logic [7:0] s;
        s = 8'd0;
        f.push_back(BOOT_SYNC_BYTE);
        f.push_back(8'(pl.size()));
        foreach (pl[i]) begin
            f.push_back(pl[i]);
            s = s + pl[i];
        end
        if (CHK_EN) f.push_back(8'(8'd0 - s + tweak));
        return f;
    endfunction

    task automatic do_reset();
        rx_valid = 1'b0;
        reset    = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic probe_at(input int id);
        probe = id;
        tick();
        probe = 0;
    endtask

    initial begin
        bq_t p;
        bq_t f;
        int  len;
        int  nf;
        logic [7:0] g;
        for (int i = 0; i < 256; i++) begin
            dut_ram[i]   = 8'd0;
            model_ram[i] = 8'd0;
        end
        tick();
        check_en = 1'b1;
        probe_at(10);
        reset = 1'b0;

        // Frame 11,22,33 back-to-back
        do_reset();
        wb = we_cnt;
        p = {8'h11, 8'h22, 8'h33};
        send(frame(p, 8'd0), 0);
        repeat (3) tick();
        probe_at(1);

`ifdef BOOT_LOADER_CHECKSUM_EN
        // Bad checksum, then recovery frame
        do_reset();
        f = frame(p, 8'd0);
        f[f.size() - 1] = 8'h88;
        send(f, 1);
        tick();
        probe_at(2);
        p = {8'h7E};
        send(frame(p, 8'd0), 1);
        repeat (2) tick();
        probe_at(3);
`endif

        // Garbage before SYNC
        do_reset();
        wb = we_cnt;
        f = {8'h00, 8'hFF, 8'h5A};
        send(f, 1);
        p = {8'hC3};
        send(frame(p, 8'd0), 1);
        repeat (2) tick();
        probe_at(4);

        // Zero length
        do_reset();
        wb = we_cnt;
        f = {BOOT_SYNC_BYTE, 8'h00};
        send(f, 0);
        probe_at(5);

        // Reset after two of four payload bytes
        do_reset();
        f = {BOOT_SYNC_BYTE, 8'h04, 8'h01, 8'h02};
        send(f, 0);
        tick();
        do_reset();
        probe_at(6);
        p = {8'h55};
        send(frame(p, 8'd0), 0);
        repeat (2) tick();
        probe_at(7);

        // valid toggling through the payload, then bytes in DONE
        do_reset();
        wb = we_cnt;
        p = {8'h10, 8'h20, 8'h30, 8'h40};
        send(frame(p, 8'd0), 2);
        tick();
        f = {BOOT_SYNC_BYTE, 8'h01, 8'h99};
        send(f, 0);
        probe_at(8);

        // Random frames
        for (int it = 0; it < 25; it++) begin
            do_reset();
            repeat ($urandom_range(0, 3)) begin
                g = 8'($urandom);
                if (g == BOOT_SYNC_BYTE) g = 8'h00;
                put(g, $urandom_range(0, 1));
            end
            nf = $urandom_range(1, 2);
            for (int k = 0; k < nf; k++) begin
                if ($urandom_range(0, 7) == 0) begin
                    len = 0;
                end else if ($urandom_range(0, 9) == 0) begin
                    len = $urandom_range(100, 255);
                end else begin
                    len = $urandom_range(1, 8);
                end
                if (len == 0) begin
                    f = {BOOT_SYNC_BYTE, 8'h00};
                end else begin
                    p.delete();
                    repeat (len) p.push_back(8'($urandom));
                    f = frame(p, ($urandom_range(0, 2) == 0) ? 8'd1 : 8'd0);
                end
                send(f, $urandom_range(0, 2));
            end
            repeat (3) tick();
            probe_at(9);
        end

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
